// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: MMIO register window in front of the UART byte interface.
// RX and TX bytes are buffered in two small FIFOs. Loads return registered
// data one cycle after re_in, matching data-memory latency.
// Optional feature macro: MMIO_UART_IRQ_EN adds the IRQ_EN register (+0xC)
// and the registered irq_out port.
module mmio_uart_ctrl #(
  parameter int          AWIDTH     = 32,
  parameter int          DWIDTH     = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] addr_in,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              we_in,
  input  logic              re_in,
  output logic [DWIDTH-1:0] data_reg_out,
  input  logic [7:0]        uart_rx_data_in,
  input  logic              uart_rx_valid_in,
  output logic              uart_rx_ready_out,
  output logic [7:0]        uart_tx_data_out,
  output logic              uart_tx_valid_out,
`ifdef MMIO_UART_IRQ_EN
  output logic              irq_out,
`endif
  input  logic              uart_tx_ready_in
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [AWIDTH-1:0] BASE      = AWIDTH'(BASE_ADDR);
  localparam logic [AWIDTH-1:0] A_STATUS  = BASE;
  localparam logic [AWIDTH-1:0] A_RX_DATA = BASE + AWIDTH'(4);
  localparam logic [AWIDTH-1:0] A_TX_DATA = BASE + AWIDTH'(8);
`ifdef MMIO_UART_IRQ_EN
  localparam logic [AWIDTH-1:0] A_IRQ_EN  = BASE + AWIDTH'(12);
`endif

  // RX FIFO state
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] rx_count;
  logic          rx_full, rx_empty, rx_push, rx_pop;

  // TX FIFO state
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] tx_count;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  // Register access decode
  logic              hit_status, hit_rx, hit_tx;
  logic              status_rd, rx_rd, tx_wr;
  logic              tx_ovf_evt, rx_udf_evt;
  logic              tx_overflow, rx_underflow;
  logic [DWIDTH-1:0] status_word;
  logic [DWIDTH-1:0] rd_data;

  // Only the low byte of store data is architecturally meaningful.
  logic unused_data;
  assign unused_data = ^data_in[DWIDTH-1:8];

  assign hit_status = (addr_in == A_STATUS);
  assign hit_rx     = (addr_in == A_RX_DATA);
  assign hit_tx     = (addr_in == A_TX_DATA);

  assign status_rd  = re_in & hit_status;
  assign rx_rd      = re_in & hit_rx;
  assign tx_wr      = we_in & hit_tx;

  assign rx_full    = (rx_count == FULL_CNT);
  assign rx_empty   = (rx_count == '0);
  assign tx_full    = (tx_count == FULL_CNT);
  assign tx_empty   = (tx_count == '0);

  // Full/empty are judged on pre-edge counts, so a same-cycle pop never
  // makes room for a push that arrives at a full FIFO.
  assign uart_rx_ready_out = ~rx_full;
  assign rx_push    = uart_rx_valid_in & ~rx_full;
  assign rx_pop     = rx_rd & ~rx_empty;
  assign rx_udf_evt = rx_rd & rx_empty;

  assign uart_tx_valid_out = ~tx_empty;
  assign uart_tx_data_out  = tx_mem[tx_rd_ptr];
  assign tx_push    = tx_wr & ~tx_full;
  assign tx_pop     = ~tx_empty & uart_tx_ready_in;
  assign tx_ovf_evt = tx_wr & tx_full;

  // RX storage: written at the write pointer on each accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= '0;
    end else if (rx_push) begin
      rx_mem[rx_wr_ptr] <= uart_rx_data_in;
    end
  end

  // RX pointers and occupancy; push and pop together leave the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // TX storage: written from the low byte of store data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem[i] <= '0;
    end else if (tx_push) begin
      tx_mem[tx_wr_ptr] <= data_in[7:0];
    end
  end

  // TX pointers and occupancy; push and pop together leave the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // Sticky error flags: a STATUS read clears them, a new event on the same
  // edge takes priority and keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (tx_ovf_evt)     tx_overflow <= 1'b1;
      else if (status_rd) tx_overflow <= 1'b0;
      if (rx_udf_evt)     rx_underflow <= 1'b1;
      else if (status_rd) rx_underflow <= 1'b0;
    end
  end

`ifdef MMIO_UART_IRQ_EN
  logic [1:0] irq_en;
  logic       hit_irq;
  assign hit_irq = (addr_in == A_IRQ_EN);

  // IRQ enable register and registered interrupt (one cycle behind state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en  <= 2'b00;
      irq_out <= 1'b0;
    end else begin
      if (we_in & hit_irq) irq_en <= data_in[1:0];
      irq_out <= (~rx_empty & irq_en[0]) | (tx_empty & irq_en[1]);
    end
  end
`endif

  // STATUS layout: flags in [3:0], rx_count at [11:8], tx_count at [19:16].
  always_comb begin
    status_word          = '0;
    status_word[0]       = ~tx_full;
    status_word[1]       = ~rx_empty;
    status_word[2]       = tx_overflow;
    status_word[3]       = rx_underflow;
    status_word[8 +: CW]  = rx_count;
    status_word[16 +: CW] = tx_count;
  end

  // Load data select; unmapped and write-only offsets read as zero.
  always_comb begin
    rd_data = '0;
    if (hit_status) begin
      rd_data = status_word;
    end else if (hit_rx) begin
      rd_data = rx_empty ? '0 : DWIDTH'(rx_mem[rx_rd_ptr]);
    end
`ifdef MMIO_UART_IRQ_EN
    else if (hit_irq) begin
      rd_data = DWIDTH'(irq_en);
    end
`endif
  end

  // Registered load data; returns zero on any cycle without a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_reg_out <= '0;
    else        data_reg_out <= re_in ? rd_data : '0;
  end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed testbench for mmio_uart_ctrl (default FIFO_DEPTH = 4).
// IRQ scenario is built only when MMIO_UART_IRQ_EN is defined.
module tb_mmio_uart_ctrl;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] A_ST = BASE;
  localparam logic [31:0] A_RX = BASE + 32'h4;
  localparam logic [31:0] A_TX = BASE + 32'h8;
  localparam logic [31:0] A_IE = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] addr_in = '0;
  logic [31:0] data_in = '0;
  logic        we_in = 1'b0;
  logic        re_in = 1'b0;
  logic [31:0] data_reg_out;
  logic [7:0]  uart_rx_data_in = '0;
  logic        uart_rx_valid_in = 1'b0;
  logic        uart_rx_ready_out;
  logic [7:0]  uart_tx_data_out;
  logic        uart_tx_valid_out;
  logic        uart_tx_ready_in = 1'b0;
  logic        irq_out;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_uart_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .addr_in           (addr_in),
    .data_in           (data_in),
    .we_in             (we_in),
    .re_in             (re_in),
    .data_reg_out      (data_reg_out),
    .uart_rx_data_in   (uart_rx_data_in),
    .uart_rx_valid_in  (uart_rx_valid_in),
    .uart_rx_ready_out (uart_rx_ready_out),
    .uart_tx_data_out  (uart_tx_data_out),
    .uart_tx_valid_out (uart_tx_valid_out),
`ifdef MMIO_UART_IRQ_EN
    .irq_out           (irq_out),
`endif
    .uart_tx_ready_in  (uart_tx_ready_in)
  );

`ifndef MMIO_UART_IRQ_EN
  assign irq_out = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_read(input logic [31:0] a, output logic [31:0] d);
    addr_in = a;
    re_in   = 1'b1;
    tick();
    d       = data_reg_out;
    re_in   = 1'b0;
    addr_in = '0;
  endtask

  task automatic mmio_write(input logic [31:0] a, input logic [31:0] d);
    addr_in = a;
    data_in = d;
    we_in   = 1'b1;
    tick();
    we_in   = 1'b0;
    addr_in = '0;
    data_in = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (data_reg_out !== 32'h0) begin n_fail++; $display("FAIL rst_data got=%h exp=%h", data_reg_out, 32'h0); end
    n_checks++;
    if (uart_tx_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid got=%b exp=0", uart_tx_valid_out); end
    n_checks++;
    if (uart_rx_ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_rx_ready got=%b exp=1", uart_rx_ready_out); end
    n_checks++;
    if (uart_tx_data_out !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data got=%h exp=00", uart_tx_data_out); end
    rst_n = 1'b1;
    tick();
    mmio_read(A_ST, d);
    n_checks++;
    if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL rst_status got=%h exp=%h", d, 32'h1); end
    tick();
    n_checks++;
    if (data_reg_out !== 32'h0) begin n_fail++; $display("FAIL read_not_held got=%h exp=0", data_reg_out); end
  endtask

  task automatic test_tx_basic();
    logic [31:0] d;
    uart_tx_ready_in = 1'b0;
    mmio_write(A_TX, 32'h0000_0041);
    mmio_write(A_TX, 32'hFFFF_FF42);
    mmio_read(A_ST, d);
    n_checks++;
    if (d !== 32'h0002_0001) begin n_fail++; $display("FAIL tx_status got=%h exp=%h", d, 32'h0002_0001); end
    uart_tx_ready_in = 1'b1;
    n_checks++;
    if (uart_tx_valid_out !== 1'b1 || uart_tx_data_out !== 8'h41) begin
      n_fail++; $display("FAIL tx_first got=%b/%h exp=1/41", uart_tx_valid_out, uart_tx_data_out);
    end
    tick();
    n_checks++;
    if (uart_tx_valid_out !== 1'b1 || uart_tx_data_out !== 8'h42) begin
      n_fail++; $display("FAIL tx_second got=%b/%h exp=1/42", uart_tx_valid_out, uart_tx_data_out);
    end
    tick();
    n_checks++;
    if (uart_tx_valid_out !== 1'b0) begin n_fail++; $display("FAIL tx_drained got=%b exp=0", uart_tx_valid_out); end
    uart_tx_ready_in = 1'b0;
  endtask

  task automatic test_rx_full();
    logic [31:0] d;
    uart_rx_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      uart_rx_data_in = 8'h10 + 8'(i);
      n_checks++;
      if (uart_rx_ready_out !== 1'b1) begin n_fail++; $display("FAIL rx_fill_ready[%0d] got=%b exp=1", i, uart_rx_ready_out); end
      tick();
    end
    uart_rx_data_in = 8'h14;
    n_checks++;
    if (uart_rx_ready_out !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready got=%b exp=0", uart_rx_ready_out); end
    tick();
    mmio_read(A_RX, d);
    n_checks++;
    if (d !== 32'h10) begin n_fail++; $display("FAIL rx_read0 got=%h exp=10", d); end
    n_checks++;
    if (uart_rx_ready_out !== 1'b1) begin n_fail++; $display("FAIL rx_ready_after_pop got=%b exp=1", uart_rx_ready_out); end
    tick();
    uart_rx_valid_in = 1'b0;
    for (int i = 1; i < 5; i++) begin
      mmio_read(A_RX, d);
      n_checks++;
      if (d !== 32'h10 + 32'(i)) begin n_fail++; $display("FAIL rx_read%0d got=%h exp=%h", i, d, 32'h10 + 32'(i)); end
    end
    mmio_read(A_ST, d);
    n_checks++;
    if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL rx_empty_status got=%h exp=1", d); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    uart_tx_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) mmio_write(A_TX, 32'hA0 + 32'(i));
    mmio_read(A_ST, d);
    n_checks++;
    if (d !== 32'h0004_0004) begin n_fail++; $display("FAIL ovf_status got=%h exp=%h", d, 32'h0004_0004); end
    mmio_read(A_ST, d);
    n_checks++;
    if (d !== 32'h0004_0000) begin n_fail++; $display("FAIL ovf_cleared got=%h exp=%h", d, 32'h0004_0000); end
    // Write into a full FIFO while the transmitter drains it on the same edge.
    uart_tx_ready_in = 1'b1;
    mmio_write(A_TX, 32'hA5);
    uart_tx_ready_in = 1'b0;
    mmio_read(A_ST, d);
    n_checks++;
    if (d !== 32'h0003_0005) begin n_fail++; $display("FAIL ovf_no_rescue got=%h exp=%h", d, 32'h0003_0005); end
    uart_tx_ready_in = 1'b1;
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (uart_tx_valid_out !== 1'b1 || uart_tx_data_out !== 8'hA0 + 8'(i)) begin
        n_fail++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, uart_tx_valid_out, uart_tx_data_out, 8'hA0 + 8'(i));
      end
      tick();
    end
    n_checks++;
    if (uart_tx_valid_out !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got=%b exp=0", uart_tx_valid_out); end
    uart_tx_ready_in = 1'b0;
    mmio_read(A_ST, d);
  endtask

  task automatic test_rx_underflow();
    logic [31:0] d;
    uart_rx_valid_in = 1'b1;
    uart_rx_data_in  = 8'h55;
    mmio_read(A_RX, d);
    uart_rx_valid_in = 1'b0;
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL udf_read got=%h exp=0", d); end
    mmio_read(A_RX, d);
    n_checks++;
    if (d !== 32'h55) begin n_fail++; $display("FAIL udf_next got=%h exp=55", d); end
    mmio_read(A_ST, d);
    n_checks++;
    if (d !== 32'h0000_0009) begin n_fail++; $display("FAIL udf_status got=%h exp=9", d); end
    mmio_read(A_ST, d);
    n_checks++;
    if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL udf_cleared got=%h exp=1", d); end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    mmio_write(BASE + 32'h10, 32'h99);
    n_checks++;
    if (uart_tx_valid_out !== 1'b0) begin n_fail++; $display("FAIL unmapped_write got=%b exp=0", uart_tx_valid_out); end
    mmio_read(BASE + 32'h1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL alias_read got=%h exp=0", d); end
    mmio_read(32'h0000_0000, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL low_addr_read got=%h exp=0", d); end
`ifndef MMIO_UART_IRQ_EN
    mmio_write(A_IE, 32'h3);
    mmio_read(A_IE, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL irq_reg_absent got=%h exp=0", d); end
`endif
    // Simultaneous load and store on TX_DATA: store pushes, load reads zero.
    addr_in = A_TX; data_in = 32'h77; we_in = 1'b1; re_in = 1'b1;
    tick();
    we_in = 1'b0; re_in = 1'b0; addr_in = '0;
    n_checks++;
    if (data_reg_out !== 32'h0) begin n_fail++; $display("FAIL both_rd got=%h exp=0", data_reg_out); end
    n_checks++;
    if (uart_tx_valid_out !== 1'b1 || uart_tx_data_out !== 8'h77) begin
      n_fail++; $display("FAIL both_wr got=%b/%h exp=1/77", uart_tx_valid_out, uart_tx_data_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    uart_rx_valid_in = 1'b1;
    uart_rx_data_in  = 8'h3C;
    tick();
    uart_rx_valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (uart_tx_valid_out !== 1'b0 || uart_tx_data_out !== 8'h00 || uart_rx_ready_out !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset got=%b/%h/%b exp=0/00/1", uart_tx_valid_out, uart_tx_data_out, uart_rx_ready_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    mmio_read(A_ST, d);
    n_checks++;
    if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL mid_reset_status got=%h exp=1", d); end
    mmio_read(A_RX, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rx got=%h exp=0", d); end
    mmio_read(A_ST, d);
  endtask

`ifdef MMIO_UART_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    mmio_write(A_IE, 32'h1);
    mmio_read(A_IE, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL irq_en_read got=%h exp=1", d); end
    n_checks++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL irq_idle got=%b exp=0", irq_out); end
    uart_rx_valid_in = 1'b1;
    uart_rx_data_in  = 8'h66;
    tick();
    uart_rx_valid_in = 1'b0;
    n_checks++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL irq_lag got=%b exp=0", irq_out); end
    tick();
    n_checks++;
    if (irq_out !== 1'b1) begin n_fail++; $display("FAIL irq_rise got=%b exp=1", irq_out); end
    mmio_read(A_RX, d);
    n_checks++;
    if (d !== 32'h66 || irq_out !== 1'b1) begin n_fail++; $display("FAIL irq_pop got=%h/%b exp=66/1", d, irq_out); end
    tick();
    n_checks++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL irq_fall got=%b exp=0", irq_out); end
    mmio_write(A_IE, 32'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_tx_basic();
    test_rx_full();
    test_tx_overflow();
    test_rx_underflow();
    test_decode();
    test_reset_mid();
`ifdef MMIO_UART_IRQ_EN
    test_irq();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
